// File: rtl/instr_sequencer_if.sv
// Fetch, register-file, ALU and data-memory signals between the sequencer and the datapath.
// The master side is the sequencer. The slave side is the fetch/datapath/memory environment.
interface instr_sequencer_if;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [2:0]  rf_addrA;
   logic [2:0]  rf_addrB;
   logic [2:0]  rf_addrR;
   logic        rf_we;
   logic [2:0]  alu_op;
   logic        alu_src_imm;
   logic [15:0] imm;
   logic        wb_sel;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready;

   modport master (
      input  instr_valid, instr, mem_ready,
      output instr_ready, rf_addrA, rf_addrB, rf_addrR, rf_we,
             alu_op, alu_src_imm, imm, wb_sel, mem_req, mem_we
   );

   modport slave (
      output instr_valid, instr, mem_ready,
      input  instr_ready, rf_addrA, rf_addrB, rf_addrR, rf_we,
             alu_op, alu_src_imm, imm, wb_sel, mem_req, mem_we
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: accept, decode, execute, memory, writeback.
// Counts retired instructions and flags illegal opcodes and memory timeouts.
module instr_sequencer #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   instr_sequencer_if.master bus,
   output logic             illegal,
   output logic             mem_err,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_LD   = 4'h7;
   localparam logic [3:0] OP_ST   = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Last MEM cycle index (counter starts at 0 on MEM entry).
   localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] RET_ONE   = CNT_W'(1);

   state_t           state_reg;
   logic [15:0]      ir_reg;
   logic [7:0]       wait_cnt_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             instr_ready_reg;
   logic             rf_we_reg;
   logic             mem_req_reg;
   logic             mem_we_reg;
   logic             illegal_reg;
   logic             mem_err_reg;
   logic             halted_reg;

   logic [3:0]  op;
   logic [2:0]  rd;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic [2:0]  alu_op_next;
   logic        is_alu_wb;
   logic        is_mem;

   assign op  = ir_reg[15:12];
   assign rd  = ir_reg[11:9];
   assign rs1 = ir_reg[8:6];
   assign rs2 = ir_reg[5:3];

   always_comb begin
      alu_op_next = 3'd0;
      is_alu_wb   = 1'b0;
      is_mem      = 1'b0;
      case (op)
         OP_ADD:  begin alu_op_next = 3'd0; is_alu_wb = 1'b1; end
         OP_SUB:  begin alu_op_next = 3'd1; is_alu_wb = 1'b1; end
         OP_AND:  begin alu_op_next = 3'd2; is_alu_wb = 1'b1; end
         OP_OR:   begin alu_op_next = 3'd3; is_alu_wb = 1'b1; end
         OP_XOR:  begin alu_op_next = 3'd4; is_alu_wb = 1'b1; end
         OP_ADDI: begin alu_op_next = 3'd0; is_alu_wb = 1'b1; end
         OP_LD:   begin alu_op_next = 3'd0; is_mem    = 1'b1; end
         OP_ST:   begin alu_op_next = 3'd0; is_mem    = 1'b1; end
         default: ;
      endcase
   end

   // Datapath steering comes straight from IR, so it stays stable for the whole instruction.
   assign bus.rf_addrA    = rs1;
   assign bus.rf_addrB    = (op == OP_ST) ? rd : rs2;
   assign bus.rf_addrR    = rd;
   assign bus.alu_op      = alu_op_next;
   assign bus.alu_src_imm = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
   assign bus.imm         = {{10{ir_reg[5]}}, ir_reg[5:0]};
   assign bus.wb_sel      = (op == OP_LD);

   assign bus.instr_ready = instr_ready_reg;
   assign bus.rf_we       = rf_we_reg;
   assign bus.mem_req     = mem_req_reg;
   assign bus.mem_we      = mem_we_reg;
   assign illegal         = illegal_reg;
   assign mem_err         = mem_err_reg;
   assign halted          = halted_reg;
   assign retired         = retired_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= S_IDLE;
         ir_reg          <= 16'h0000;
         wait_cnt_reg    <= 8'd0;
         retired_reg     <= '0;
         instr_ready_reg <= 1'b1;
         rf_we_reg       <= 1'b0;
         mem_req_reg     <= 1'b0;
         mem_we_reg      <= 1'b0;
         illegal_reg     <= 1'b0;
         mem_err_reg     <= 1'b0;
         halted_reg      <= 1'b0;
      end else begin
         illegal_reg <= 1'b0;
         mem_err_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.instr_valid && instr_ready_reg) begin
                  ir_reg          <= bus.instr;
                  instr_ready_reg <= 1'b0;
                  state_reg       <= S_DECODE;
               end
            end
            S_DECODE: begin
               state_reg <= S_EXEC;
            end
            S_EXEC: begin
               if (is_alu_wb) begin
                  rf_we_reg <= 1'b1;
                  state_reg <= S_WB;
               end else if (is_mem) begin
                  mem_req_reg  <= 1'b1;
                  mem_we_reg   <= (op == OP_ST);
                  wait_cnt_reg <= 8'd0;
                  state_reg    <= S_MEM;
               end else if (op == OP_HALT) begin
                  halted_reg  <= 1'b1;
                  retired_reg <= retired_reg + RET_ONE;
                  state_reg   <= S_HALT;
               end else begin
                  // NOP and undefined opcodes both retire without side effects.
                  illegal_reg     <= (op != OP_NOP);
                  retired_reg     <= retired_reg + RET_ONE;
                  instr_ready_reg <= 1'b1;
                  state_reg       <= S_IDLE;
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  if (op == OP_LD) begin
                     rf_we_reg <= 1'b1;
                     state_reg <= S_WB;
                  end else begin
                     retired_reg     <= retired_reg + RET_ONE;
                     instr_ready_reg <= 1'b1;
                     state_reg       <= S_IDLE;
                  end
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  mem_req_reg     <= 1'b0;
                  mem_we_reg      <= 1'b0;
                  mem_err_reg     <= 1'b1;
                  retired_reg     <= retired_reg + RET_ONE;
                  instr_ready_reg <= 1'b1;
                  state_reg       <= S_IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            S_WB: begin
               rf_we_reg       <= 1'b0;
               retired_reg     <= retired_reg + RET_ONE;
               instr_ready_reg <= 1'b1;
               state_reg       <= S_IDLE;
            end
            S_HALT: begin
               state_reg <= S_HALT;
            end
            default: begin
               state_reg       <= S_IDLE;
               instr_ready_reg <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ALU, LD, ST timeout, illegal/HALT, reset abort, counter wrap.
module tb_instr_sequencer;
   logic       clk;
   logic       reset_n;
   logic       illegal;
   logic       mem_err;
   logic       halted;
   logic [3:0] retired;

   int checks = 0;
   int errors = 0;

   instr_sequencer_if bus ();

   instr_sequencer #(.WAIT_MAX(15), .CNT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .illegal (illegal),
      .mem_err (mem_err),
      .halted  (halted),
      .retired (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int req_cnt;
      int err_cnt;
      int we_cnt;
      int memwe_cnt;
      int rdy_cnt;

      reset_n         = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      bus.mem_ready   = 1'b0;

      // Reset state
      #2;
      check("rst_rf_we",   32'(bus.rf_we),   32'd0);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mem_we",  32'(bus.mem_we),  32'd0);
      check("rst_illegal", 32'(illegal),     32'd0);
      check("rst_mem_err", 32'(mem_err),     32'd0);
      check("rst_halted",  32'(halted),      32'd0);
      check("rst_retired", 32'(retired),     32'd0);
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("rst_ready", 32'(bus.instr_ready), 32'd1);
      $display("reset: ready=%0d retired=%0d", bus.instr_ready, retired);

      // ADD r3,r1,r2; fetch changes instr while busy, which must be ignored
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h1650;
      tick();
      bus.instr = 16'h2FFF;
      check("add_addrA",  32'(bus.rf_addrA),    32'd1);
      check("add_addrB",  32'(bus.rf_addrB),    32'd2);
      check("add_aluop",  32'(bus.alu_op),      32'd0);
      check("add_srcimm", 32'(bus.alu_src_imm), 32'd0);
      check("add_busy",   32'(bus.instr_ready), 32'd0);
      tick();
      bus.instr_valid = 1'b0;
      check("add_nolatch", 32'(bus.rf_addrA), 32'd1);
      check("add_we_c2",   32'(bus.rf_we),    32'd0);
      tick();
      check("add_we_c3",   32'(bus.rf_we),    32'd1);
      check("add_addrR",   32'(bus.rf_addrR), 32'd3);
      check("add_wbsel",   32'(bus.wb_sel),   32'd0);
      check("add_noreq",   32'(bus.mem_req),  32'd0);
      tick();
      check("add_we_c4",   32'(bus.rf_we),       32'd0);
      check("add_ready",   32'(bus.instr_ready), 32'd1);
      check("add_retired", 32'(retired),         32'd1);
      $display("ADD 0x1650: retired=%0d", retired);

      // LD r5,[r2-1] with mem_ready on the third MEM cycle
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h7ABF;
      tick();
      bus.instr_valid = 1'b0;
      check("ld_imm",    32'(bus.imm),         32'h0000FFFF);
      check("ld_srcimm", 32'(bus.alu_src_imm), 32'd1);
      check("ld_addrA",  32'(bus.rf_addrA),    32'd2);
      check("ld_aluop",  32'(bus.alu_op),      32'd0);
      tick();
      check("ld_req_c2", 32'(bus.mem_req), 32'd0);
      tick();
      check("ld_req_c3", 32'(bus.mem_req), 32'd1);
      check("ld_we_c3",  32'(bus.mem_we),  32'd0);
      tick();
      check("ld_req_c4", 32'(bus.mem_req), 32'd1);
      tick();
      check("ld_req_c5", 32'(bus.mem_req), 32'd1);
      check("ld_rfwe_c5", 32'(bus.rf_we),  32'd0);
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      check("ld_req_c6",  32'(bus.mem_req),  32'd0);
      check("ld_rfwe_c6", 32'(bus.rf_we),    32'd1);
      check("ld_wbsel",   32'(bus.wb_sel),   32'd1);
      check("ld_addrR",   32'(bus.rf_addrR), 32'd5);
      tick();
      check("ld_rfwe_c7", 32'(bus.rf_we),       32'd0);
      check("ld_ready",   32'(bus.instr_ready), 32'd1);
      check("ld_retired", 32'(retired),         32'd2);
      $display("LD 0x7ABF: retired=%0d", retired);

      // ST r4,[r1+3] with memory never answering
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h8843;
      tick();
      bus.instr_valid = 1'b0;
      check("st_addrB", 32'(bus.rf_addrB), 32'd4);
      check("st_addrA", 32'(bus.rf_addrA), 32'd1);
      check("st_imm",   32'(bus.imm),      32'h00000003);
      tick();
      req_cnt = 0; err_cnt = 0; we_cnt = 0; memwe_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.mem_req) req_cnt++;
         if (mem_err) err_cnt++;
         if (bus.rf_we) we_cnt++;
         if (bus.mem_req && bus.mem_we) memwe_cnt++;
      end
      check("st_req_cycles", 32'(req_cnt),   32'd15);
      check("st_we_cycles",  32'(memwe_cnt), 32'd15);
      check("st_err_pulses", 32'(err_cnt),   32'd1);
      check("st_no_rfwe",    32'(we_cnt),    32'd0);
      check("st_retired",    32'(retired),   32'd3);
      check("st_ready",      32'(bus.instr_ready), 32'd1);
      $display("ST 0x8843 timeout: req=%0d err=%0d retired=%0d", req_cnt, err_cnt, retired);

      // Illegal opcode 0xB
      bus.instr_valid = 1'b1;
      bus.instr       = 16'hB000;
      tick();
      bus.instr_valid = 1'b0;
      tick();
      check("ill_pre", 32'(illegal), 32'd0);
      tick();
      check("ill_pulse",   32'(illegal),         32'd1);
      check("ill_ready",   32'(bus.instr_ready), 32'd1);
      check("ill_retired", 32'(retired),         32'd4);
      check("ill_no_rfwe", 32'(bus.rf_we),       32'd0);
      $display("ILL 0xB000: retired=%0d", retired);

      // HALT, then an ADD that must never be accepted
      bus.instr_valid = 1'b1;
      bus.instr       = 16'hF000;
      tick();
      bus.instr_valid = 1'b0;
      check("ill_once", 32'(illegal), 32'd0);
      tick();
      tick();
      check("halt_halted",  32'(halted),          32'd1);
      check("halt_ready",   32'(bus.instr_ready), 32'd0);
      check("halt_retired", 32'(retired),         32'd5);
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h1650;
      rdy_cnt = 0; we_cnt = 0; req_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.instr_ready) rdy_cnt++;
         if (bus.rf_we) we_cnt++;
         if (bus.mem_req) req_cnt++;
      end
      check("halt_no_ready", 32'(rdy_cnt), 32'd0);
      check("halt_no_rfwe",  32'(we_cnt),  32'd0);
      check("halt_no_req",   32'(req_cnt), 32'd0);
      check("halt_stuck",    32'(halted),  32'd1);
      check("halt_ret_hold", 32'(retired), 32'd5);
      $display("HALT: halted=%0d retired=%0d", halted, retired);

      // Reset leaves HALT; the pending ADD is then aborted in WB
      reset_n = 1'b0;
      #1;
      check("rst2_halted",  32'(halted),  32'd0);
      check("rst2_retired", 32'(retired), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("rst2_accept", 32'(bus.instr_ready), 32'd0);
      bus.instr_valid = 1'b0;
      tick();
      tick();
      check("abort_we_wb", 32'(bus.rf_we), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_we_async", 32'(bus.rf_we), 32'd0);
      check("abort_retired",  32'(retired),   32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("abort_ready",    32'(bus.instr_ready), 32'd1);
      check("abort_ret_hold", 32'(retired),         32'd0);
      check("abort_no_we",    32'(bus.rf_we),       32'd0);
      $display("reset in WB: retired=%0d ready=%0d", retired, bus.instr_ready);

      // Back-to-back NOPs wrap the 4-bit counter
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h0000;
      for (int n = 0; n < 15; n++) begin
         tick();
         tick();
         tick();
      end
      check("nop_ret15", 32'(retired),         32'd15);
      check("nop_ready", 32'(bus.instr_ready), 32'd1);
      tick();
      bus.instr_valid = 1'b0;
      tick();
      tick();
      check("nop_wrap",   32'(retired),         32'd0);
      check("nop_ready2", 32'(bus.instr_ready), 32'd1);
      $display("NOP x16: retired=%0d", retired);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
